// File: rtl/fp13_pkg.sv
// Shared field layout, widths and FSM encoding for the fp13 <-> s8 datapath.
package fp13_pkg;
  localparam int FP13_SIGN     = 12;
  localparam int FP13_EXP_MSB  = 11;
  localparam int FP13_EXP_LSB  = 8;
  localparam int FP13_FRAC_MSB = 7;
  localparam int EXP_W  = 4;
  localparam int FRAC_W = 8;
  localparam int MAG_W  = 7;

  localparam logic [EXP_W-1:0] EXP_MAX_S8 = 4'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/fp13_classify.sv
// Combinational classifier for an fp13 operand: special cases and the
// number of right shifts needed to denormalize the fraction.
module fp13_classify
  import fp13_pkg::*;
(
  input  logic [12:0] fp13,
  output logic        is_zero,
  output logic        is_uf,
  output logic        is_of,
  output logic [2:0]  shift_cnt
);
  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac;

  assign exp_f = fp13[FP13_EXP_MSB:FP13_EXP_LSB];
  assign frac  = fp13[FP13_FRAC_MSB:0];

  // zero wins over the exponent checks, then underflow, then overflow
  assign is_zero = (frac == '0);
  assign is_uf   = !is_zero && (exp_f == '0);
  assign is_of   = !is_zero && (exp_f > EXP_MAX_S8);

  // 8-exp modulo 8; only meaningful for exp in 1..7
  assign shift_cnt = 3'd0 - exp_f[2:0];
endmodule

// File: rtl/fp13_to_s8_seq.sv
// Multi-cycle fp13 -> 8-bit sign-magnitude converter; the fraction is
// denormalized one bit per cycle under a down-counter.
module fp13_to_s8_seq
  import fp13_pkg::*;
#(
  parameter bit SAT_ON_OF = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] in_fp13,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_s8,
  output logic        out_of,
  output logic        out_uf
);
  state_t            state, state_nxt;
  logic [FRAC_W-1:0] shreg, shreg_nxt;
  logic [2:0]        cnt;
  logic              sign_q;
  logic              is_zero, is_uf, is_of;
  logic [2:0]        shift_cnt;
  logic              fire_in, special;
  logic [MAG_W-1:0]  special_mag;

  fp13_classify u_classify (
    .fp13      (in_fp13),
    .is_zero   (is_zero),
    .is_uf     (is_uf),
    .is_of     (is_of),
    .shift_cnt (shift_cnt)
  );

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign fire_in     = in_valid && in_ready;
  assign special     = is_zero || is_uf || is_of;
  assign special_mag = (is_of && SAT_ON_OF) ? 7'h7F : 7'h00;
  assign shreg_nxt   = shreg >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire_in) state_nxt = special ? DONE : SHIFT;
      SHIFT:   if (cnt == 3'd1) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // result registers change only on entry to DONE, so they hold while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      out_s8 <= 8'h00;
      out_of <= 1'b0;
      out_uf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fire_in) begin
          sign_q <= in_fp13[FP13_SIGN];
          if (special) begin
            out_s8 <= {in_fp13[FP13_SIGN], special_mag};
            out_of <= is_of;
            out_uf <= is_uf;
          end else begin
            shreg <= in_fp13[FP13_FRAC_MSB:0];
            cnt   <= shift_cnt;
          end
        end
        SHIFT: begin
          shreg <= shreg_nxt;
          cnt   <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            out_s8 <= {sign_q, shreg_nxt[MAG_W-1:0]};
            out_of <= 1'b0;
            out_uf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
